// File: rtl/slide_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : slide_pattern_ctrl
// Brief    : Single moving-dot LED sequencer with prescaler and start/stop/step
//            control. Optional macro SLIDE_SIM_FAST_EN selects the short
//            SIM_COUNT tick period for simulation.
// Revision : 1.0 - initial release
// ============================================================================
module slide_pattern_ctrl #(
    parameter int                WIDTH      = 16,
    parameter int                CNT_W      = 26,
    parameter logic [CNT_W-1:0]  BASE_COUNT = 26'h3FFFFFF,
    parameter int                SIM_COUNT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             wrap
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_pause = 2'd2;

    localparam logic c_dir_right = 1'b0;
    localparam logic c_dir_left  = 1'b1;

    localparam logic [WIDTH-1:0] c_msb      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_lsb      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_msb_next = c_msb >> 1;
    localparam logic [WIDTH-1:0] c_lsb_next = c_lsb << 1;

`ifdef SLIDE_SIM_FAST_EN
    localparam logic c_fast = 1'b1;
`else
    localparam logic c_fast = 1'b0;
`endif
    localparam logic [CNT_W-1:0] c_base = c_fast ? CNT_W'(SIM_COUNT) : BASE_COUNT;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic             dir_q,     dir_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [1:0]       mode_q,    mode_d;
    logic [1:0]       speed_q,   speed_d;
    logic             busy_q,    busy_d;
    logic             wrap_q,    wrap_d;

    logic [CNT_W-1:0] w_scaled;
    logic [CNT_W-1:0] w_last;
    logic             w_tick;

    logic [WIDTH-1:0] w_adv_data;
    logic             w_adv_dir;
    logic             w_adv_wrap;
    logic             w_adv_end;

    // Period is BASE >> (2*speed), floored at one clock.
    assign w_scaled = c_base >> {speed_q, 1'b0};
    assign w_last   = (w_scaled == '0) ? '0 : (w_scaled - CNT_W'(1));
    assign w_tick   = (state_q == c_run) && (counter_q == w_last);

    always_comb begin
        w_adv_data = data_q;
        w_adv_dir  = dir_q;
        w_adv_wrap = 1'b0;
        w_adv_end  = 1'b0;
        case (mode_q)
            2'd0: begin
                if (data_q == c_lsb) begin
                    w_adv_data = c_msb;
                    w_adv_wrap = 1'b1;
                end else begin
                    w_adv_data = data_q >> 1;
                end
            end
            2'd1: begin
                if (data_q == c_msb) begin
                    w_adv_data = c_lsb;
                    w_adv_wrap = 1'b1;
                end else begin
                    w_adv_data = data_q << 1;
                end
            end
            2'd2: begin
                // Ends reverse direction regardless of the current dir.
                if (data_q == c_lsb) begin
                    w_adv_data = c_lsb_next;
                    w_adv_dir  = c_dir_left;
                    w_adv_wrap = 1'b1;
                end else if (data_q == c_msb) begin
                    w_adv_data = c_msb_next;
                    w_adv_dir  = c_dir_right;
                    w_adv_wrap = 1'b1;
                end else if (dir_q == c_dir_left) begin
                    w_adv_data = data_q << 1;
                end else begin
                    w_adv_data = data_q >> 1;
                end
            end
            default: begin
                if (data_q == c_lsb) begin
                    w_adv_data = c_msb;
                    w_adv_dir  = c_dir_right;
                    w_adv_wrap = 1'b1;
                    w_adv_end  = 1'b1;
                end else begin
                    w_adv_data = data_q >> 1;
                end
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dir_d     = dir_q;
        counter_d = '0;
        mode_d    = mode_q;
        speed_d   = speed_q;
        wrap_d    = 1'b0;
        case (state_q)
            c_idle: begin
                data_d = c_msb;
                dir_d  = c_dir_right;
                if (start) begin
                    state_d = c_run;
                    mode_d  = mode;
                    speed_d = speed;
                end
            end
            c_run: begin
                // A stop on a tick cycle pauses without advancing.
                if (stop) begin
                    state_d = c_pause;
                end else if (w_tick) begin
                    data_d = w_adv_data;
                    dir_d  = w_adv_dir;
                    wrap_d = w_adv_wrap;
                    if (w_adv_end) begin
                        state_d = c_idle;
                    end
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            c_pause: begin
                if (stop) begin
                    state_d = c_idle;
                    data_d  = c_msb;
                    dir_d   = c_dir_right;
                end else if (start) begin
                    state_d = c_run;
                    mode_d  = mode;
                    speed_d = speed;
                end else if (step) begin
                    data_d = w_adv_data;
                    dir_d  = w_adv_dir;
                    wrap_d = w_adv_wrap;
                    if (w_adv_end) begin
                        state_d = c_idle;
                    end
                end
            end
            default: begin
                state_d = c_idle;
                data_d  = c_msb;
                dir_d   = c_dir_right;
            end
        endcase
        busy_d = (state_d != c_idle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= c_idle;
            data_q    <= c_msb;
            dir_q     <= c_dir_right;
            counter_q <= '0;
            mode_q    <= 2'd0;
            speed_q   <= 2'd0;
            busy_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            dir_q     <= dir_d;
            counter_q <= counter_d;
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            busy_q    <= busy_d;
            wrap_q    <= wrap_d;
        end
    end

    assign dataOut = data_q;
    assign busy    = busy_q;
    assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_slide_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_slide_pattern_ctrl
// Brief    : Directed + randomized bench for slide_pattern_ctrl against a
//            position-index reference model (tick base of 16 clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_slide_pattern_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        step;
    logic [1:0]  mode;
    logic [1:0]  speed;
    logic [15:0] dataOut;
    logic        busy;
    logic        wrap;

    int n_checks = 0;
    int n_errors = 0;
    int wrap_seen = 0;

    // Reference model: dot position as bit index, run/pause flags, elapsed clocks.
    int m_pos;
    bit m_running;
    bit m_paused;
    bit m_left;
    int m_mode;
    int m_speed;
    int m_cnt;
    bit m_wrap;

    slide_pattern_ctrl #(
        .WIDTH      (16),
        .CNT_W      (26),
        .BASE_COUNT (26'd16),
        .SIM_COUNT  (16)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .mode    (mode),
        .speed   (speed),
        .dataOut (dataOut),
        .busy    (busy),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos     = 15;
        m_running = 1'b0;
        m_paused  = 1'b0;
        m_left    = 1'b0;
        m_mode    = 0;
        m_speed   = 0;
        m_cnt     = 0;
        m_wrap    = 1'b0;
    endtask

    task automatic model_advance();
        m_wrap = 1'b0;
        case (m_mode)
            0: if (m_pos == 0) begin m_pos = 15; m_wrap = 1'b1; end else m_pos--;
            1: if (m_pos == 15) begin m_pos = 0; m_wrap = 1'b1; end else m_pos++;
            2: begin
                if (m_pos == 0) begin
                    m_pos = 1; m_left = 1'b1; m_wrap = 1'b1;
                end else if (m_pos == 15) begin
                    m_pos = 14; m_left = 1'b0; m_wrap = 1'b1;
                end else begin
                    m_pos = m_left ? m_pos + 1 : m_pos - 1;
                end
            end
            default: begin
                if (m_pos == 0) begin
                    m_pos = 15; m_left = 1'b0; m_wrap = 1'b1;
                    m_running = 1'b0; m_paused = 1'b0;
                end else begin
                    m_pos--;
                end
            end
        endcase
    endtask

    task automatic model_step(input bit s_start, input bit s_stop, input bit s_step,
                              input int s_mode, input int s_speed);
        int period;
        m_wrap = 1'b0;
        period = 16 >> (2 * m_speed);
        if (period < 1) period = 1;
        if (m_running) begin
            if (s_stop) begin
                m_running = 1'b0; m_paused = 1'b1; m_cnt = 0;
            end else if (m_cnt == period - 1) begin
                m_cnt = 0;
                model_advance();
            end else begin
                m_cnt++;
            end
        end else if (m_paused) begin
            if (s_stop) begin
                m_paused = 1'b0; m_pos = 15; m_left = 1'b0;
            end else if (s_start) begin
                m_paused = 1'b0; m_running = 1'b1;
                m_mode = s_mode; m_speed = s_speed; m_cnt = 0;
            end else if (s_step) begin
                model_advance();
            end
        end else if (s_start) begin
            m_running = 1'b1; m_mode = s_mode; m_speed = s_speed; m_cnt = 0;
        end
    endtask

    // Called at a negedge; applies inputs for one clock and checks after it.
    task automatic do_cycle(input string ph, input bit s_start, input bit s_stop, input bit s_step,
                            input logic [1:0] s_mode, input logic [1:0] s_speed);
        logic [31:0] e_data;
        start = s_start; stop = s_stop; step = s_step;
        mode  = s_mode;  speed = s_speed;
        @(posedge clk);
        model_step(s_start, s_stop, s_step, int'(s_mode), int'(s_speed));
        @(negedge clk);
        e_data = 32'd1 << m_pos;
        check_val({ph, ".data"},   32'(dataOut), e_data);
        check_val({ph, ".busy"},   32'(busy),    32'(m_running | m_paused));
        check_val({ph, ".wrap"},   32'(wrap),    32'(m_wrap));
        check_val({ph, ".onehot"}, 32'($onehot(dataOut)), 32'd1);
        if (wrap === 1'b1) wrap_seen++;
        start = 1'b0; stop = 1'b0; step = 1'b0;
    endtask

    task automatic idle_cycles(input string ph, input int n);
        for (int i = 0; i < n; i++)
            do_cycle(ph, 1'b0, 1'b0, 1'b0, 2'($urandom), 2'($urandom));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; mode = 2'd0; speed = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("reset.data", 32'(dataOut), 32'h8000);
        check_val("reset.busy", 32'(busy), 32'd0);
        check_val("reset.wrap", 32'(wrap), 32'd0);
        rst = 1'b1;
        idle_cycles("idle0", 3);

        // 1: slide right, P=16
        wrap_seen = 0;
        do_cycle("t1", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        check_val("t1.busy_on", 32'(busy), 32'd1);
        for (int i = 1; i <= 256; i++) begin
            idle_cycles("t1", 1);
            if (i == 16) check_val("t1.at16", 32'(dataOut), 32'h4000);
            if (i == 32) check_val("t1.at32", 32'(dataOut), 32'h2000);
        end
        check_val("t1.back", 32'(dataOut), 32'h8000);
        check_val("t1.wraps", 32'(wrap_seen), 32'd1);
        do_cycle("t1", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        do_cycle("t1", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);

        // 2: slide left, P=4
        wrap_seen = 0;
        do_cycle("t2", 1'b1, 1'b0, 1'b0, 2'd1, 2'd1);
        for (int i = 1; i <= 12; i++) begin
            idle_cycles("t2", 1);
            if (i == 4) begin
                check_val("t2.first", 32'(dataOut), 32'h0001);
                check_val("t2.wrap1", 32'(wrap), 32'd1);
            end
            if (i == 8)  check_val("t2.second", 32'(dataOut), 32'h0002);
            if (i == 12) check_val("t2.third",  32'(dataOut), 32'h0004);
        end
        do_cycle("t2", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        do_cycle("t2", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);

        // 3: bounce, P=1
        wrap_seen = 0;
        do_cycle("t3", 1'b1, 1'b0, 1'b0, 2'd2, 2'd2);
        idle_cycles("t3", 31);
        check_val("t3.pos", 32'(dataOut), 32'h4000);
        check_val("t3.wraps", 32'(wrap_seen), 32'd3);
        do_cycle("t3", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        do_cycle("t3", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);

        // 4: pause, step, resume
        do_cycle("t4", 1'b1, 1'b0, 1'b0, 2'd0, 2'd2);
        idle_cycles("t4", 5);
        check_val("t4.run0400", 32'(dataOut), 32'h0400);
        do_cycle("t4", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        idle_cycles("t4", 100);
        check_val("t4.held", 32'(dataOut), 32'h0400);
        for (int i = 0; i < 3; i++) begin
            do_cycle("t4", 1'b0, 1'b0, 1'b1, 2'd1, 2'd3);
            idle_cycles("t4", 1);
        end
        check_val("t4.stepped", 32'(dataOut), 32'h0080);
        do_cycle("t4", 1'b1, 1'b0, 1'b1, 2'd0, 2'd2);
        check_val("t4.no_extra", 32'(dataOut), 32'h0080);
        check_val("t4.resumed", 32'(busy), 32'd1);
        do_cycle("t4", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        do_cycle("t4", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        check_val("t4.idle_data", 32'(dataOut), 32'h8000);
        check_val("t4.idle_busy", 32'(busy), 32'd0);

        // 5: one-shot sweep
        wrap_seen = 0;
        do_cycle("t5", 1'b1, 1'b0, 1'b0, 2'd3, 2'd3);
        idle_cycles("t5", 16);
        check_val("t5.end_data", 32'(dataOut), 32'h8000);
        check_val("t5.end_busy", 32'(busy), 32'd0);
        check_val("t5.wraps", 32'(wrap_seen), 32'd1);
        idle_cycles("t5", 10);
        check_val("t5.still", 32'(dataOut), 32'h8000);

        // 6: async reset mid-run
        do_cycle("t6", 1'b1, 1'b0, 1'b0, 2'd0, 2'd2);
        idle_cycles("t6", 11);
        check_val("t6.pre", 32'(dataOut), 32'h0010);
        #2 rst = 1'b0;
        #1;
        check_val("t6.async_data", 32'(dataOut), 32'h8000);
        check_val("t6.async_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_cycles("t6", 10);
        check_val("t6.stays_idle", 32'(busy), 32'd0);

        // Random pulses and mode/speed churn
        for (int i = 0; i < 4000; i++) begin
            do_cycle("rnd", ($urandom % 16) == 0, ($urandom % 32) == 0, ($urandom % 6) == 0,
                     2'($urandom), 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slide_pattern_ctrl.md
Name: slide_pattern_ctrl

Overview:
- Controller that sequences the 16-bit LED bank on the lab board as a single moving dot.
- Owns the tick prescaler and the start/stop/step control.
- Four motion modes: slide right, slide left, bounce, and one-shot sweep.
- Sits between the debounced push-button pulses / switch inputs and the LED output register.

Parameters:
- WIDTH, 16: LED bank width; dot position register width.
- CNT_W, 26: prescaler counter width.
- BASE_COUNT, 26'h3FFFFFF: tick period in clocks at speed 0.
- SIM_COUNT, 16: tick period at speed 0 when SLIDE_SIM_FAST_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  single-cycle pulse: run or resume.
- stop  in  1  single-cycle pulse: pause, or clear when already paused.
- step  in  1  single-cycle pulse: advance one position while paused.
- mode  in  2  0 = slide right, 1 = slide left, 2 = bounce, 3 = one-shot right sweep.
- speed  in  2  period divisor select.
- dataOut  out  WIDTH  LED pattern; always one-hot.
- busy  out  1  high in RUN or PAUSE.
- wrap  out  1  one-cycle pulse on a wrap, reverse or sweep-end event.

Behaviour:
- Reset (rst=0, async): state=IDLE, dataOut=16'h8000, dir=right, counter=0, busy=0, wrap=0, latched mode/speed=0.
- Tick period: P = max(BASE >> (2*speed_l), 1), where BASE = BASE_COUNT.
  - counter counts 0..P-1 while in RUN; tick is an internal one-cycle strobe when counter==P-1; counter then returns to 0.
  - counter is held at 0 outside RUN.
- States:
  - IDLE: dataOut=16'h8000, dir=right.
    - start -> RUN; latch mode_l=mode, speed_l=speed.
    - stop and step are ignored.
  - RUN: dot advances one position on each tick.
    - stop -> PAUSE; dataOut is held and counter is cleared.
  - PAUSE: dataOut is held.
    - start -> RUN; re-latch mode and speed; counter restarts at 0.
    - stop -> IDLE.
    - step advances one position on the next clock using the current mode_l; state stays PAUSE.
- Simultaneous pulses: priority stop > start > step. Only the highest-priority pulse acts.
- Mode and speed inputs are ignored while in RUN. They take effect only when latched.
- Advance rules (one "advance" = a RUN tick or a PAUSE step):
  - mode 0: dataOut >> 1. 16'h0001 wraps to 16'h8000 and wrap pulses.
  - mode 1: dataOut << 1. 16'h8000 wraps to 16'h0001 and wrap pulses.
  - mode 2: move in direction dir.
    - Advance from 16'h0001 sets dir=left and moves to 16'h0002; wrap pulses.
    - Advance from 16'h8000 sets dir=right and moves to 16'h4000; wrap pulses.
  - mode 3: as mode 0, except an advance from 16'h0001 goes to IDLE with dataOut=16'h8000; wrap pulses.
- Latency: dataOut and wrap update on the clock edge after the tick or step cycle. busy follows state registered (no combinational path from inputs).
- Reset asserted mid-operation aborts immediately to the reset values. No pending step or start survives reset.
- dataOut is never zero and never has more than one bit set.

Optional Feature:
- Macro: SLIDE_SIM_FAST_EN.
- Defined: BASE = SIM_COUNT, so simulation sees ticks every few clocks.
- Undefined: BASE = BASE_COUNT, so the default gives roughly 1.3 s per step at 50 MHz.
- All other behaviour is identical in both builds.

Test Plan (SLIDE_SIM_FAST_EN defined, SIM_COUNT=16):
1. Reset, then start with mode=0, speed=0 -> busy=1. dataOut reads 8000, 4000, 2000 at 16-clock intervals. After 16 advances it returns to 8000 and wrap pulses exactly once.
2. mode=1, speed=1 (P=4), start -> dataOut 8000 -> 0001 on the first tick with wrap=1, then 0002, 0004 every 4 clocks.
3. mode=2, speed=2 (P=1), start -> 8000, 4000 ... 0001, 0002 ... 8000, 4000. wrap pulses at 0001->0002 and at 8000->4000. dataOut stays one-hot throughout.
4. RUN at 0400, then stop -> PAUSE, dataOut held at 0400 for 100 clocks. Three step pulses -> 0200, 0100, 0080. Same-cycle start+step -> resumes RUN with no extra advance. stop, stop -> IDLE with dataOut=8000, busy=0.
5. mode=3, speed=3 (P=1), start -> 16 advances, then state=IDLE, dataOut=8000, busy=0, one wrap pulse. Further ticks cause no motion.
6. rst pulled low mid-RUN at dataOut=0010 -> dataOut=8000 and busy=0 asynchronously before the next clock edge. After rst is released, the block stays IDLE until start.
